normalize_pipe: RTL and testbench

- Pipelined leading-zero-count and normalise stage for the FPU unpacker and rounder paths.
- Takes an N-bit significand with a sideband tag and returns:
  - the leading-zero count;
  - the significand left-shifted so its MSB is 1;
  - a zero flag.
- Two register stages with valid/ready backpressure and full throughput, replacing the purely combinational count where timing closure needs it.

---
 rtl/fpu_norm_pkg.sv | 20 ++
 rtl/lzc_tree.sv | 35 +++
 rtl/normalize_pipe.sv | 97 +++++++++
 tb/tb_normalize_pipe.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_norm_pkg.sv
// Shared types for the FPU normalise pipeline: result struct and width helper.
package fpu_norm_pkg;

  localparam int unsigned NORM_N    = 64;
  localparam int unsigned NORM_TAGW = 8;

  function automatic int unsigned clz_w(input int unsigned n);
    return $clog2(n) + 1;
  endfunction

  localparam int unsigned NORM_LZW = clz_w(NORM_N);

  typedef struct packed {
    logic [NORM_N-1:0]    mant;
    logic [NORM_LZW-1:0]  lz;
    logic                 zero;
    logic [NORM_TAGW-1:0] tag;
  } norm_res_t;

endpackage

// File: rtl/lzc_tree.sv
// Combinational leading-zero counter built by recursive halving; all-zero gives N.
module lzc_tree #(
  parameter int N = 64,
  parameter int M = $clog2(N)
) (
  input  logic [N-1:0] in_bits,
  output logic [M:0]   lz
);

  generate
    if (N == 2) begin : g_leaf
      always_comb begin
        lz = 2'd2;
        if (in_bits[1])      lz = 2'd0;
        else if (in_bits[0]) lz = 2'd1;
      end
    end else begin : g_node
      localparam int H  = N / 2;
      localparam int MH = $clog2(H);

      logic [MH:0] lz_hi;
      logic [MH:0] lz_lo;

      lzc_tree #(.N(H), .M(MH)) u_hi (.in_bits(in_bits[N-1:H]), .lz(lz_hi));
      lzc_tree #(.N(H), .M(MH)) u_lo (.in_bits(in_bits[H-1:0]), .lz(lz_lo));

      // Upper half empty: result is H + lz_lo, which fits as {carry, ~carry, low bits}.
      always_comb begin
        if (lz_hi[MH]) lz = {lz_lo[MH], ~lz_lo[MH], lz_lo[MH-1:0]};
        else           lz = {1'b0, lz_hi};
      end
    end
  endgenerate

endmodule

// File: rtl/normalize_pipe.sv
// Two-stage leading-zero count and left-normalise with valid/ready backpressure.
module normalize_pipe
  import fpu_norm_pkg::*;
#(
  parameter int N    = 64,
  parameter int M    = $clog2(N),
  parameter int TAGW = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [N-1:0]    in_mant,
  input  logic [TAGW-1:0] in_tag,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [N-1:0]    out_mant,
  output logic [M:0]      out_lz,
  output logic            out_zero,
  output logic [TAGW-1:0] out_tag
);

  logic            s1_valid;
  logic            s2_valid;
  logic [N-1:0]    s1_mant;
  logic [TAGW-1:0] s1_tag;
  logic [M:0]      s1_lz;
  logic [M:0]      lz1_next;
  logic [N-1:0]    mant2;
  logic [N-1:0]    shift_lvl [0:M];
  norm_res_t       s2;

  logic s2_adv;
  logic s1_adv;
  logic accept;

  assign s2_adv   = !s2_valid || out_ready;
  assign s1_adv   = !s1_valid || s2_adv;
  assign in_ready = s1_adv;
  assign accept   = in_valid && in_ready && !flush;

  lzc_tree #(.N(N), .M(M)) u_lzc (.in_bits(in_mant), .lz(lz1_next));

  // Log shifter: level k shifts by 2**k when bit k of the count is set.
  always_comb begin
    shift_lvl[0] = s1_mant;
    for (int k = 0; k < M; k++) begin
      shift_lvl[k+1] = s1_lz[k] ? (shift_lvl[k] << (2**k)) : shift_lvl[k];
    end
    mant2 = s1_lz[M] ? '0 : shift_lvl[M];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
    end else if (flush) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
    end else begin
      if (s2_adv) s2_valid <= s1_valid;
      if (s1_adv) s1_valid <= accept;
    end
  end

  // Data registers follow the advance enables only; valid bits decide what is real.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_mant <= '0;
      s1_tag  <= '0;
      s1_lz   <= '0;
    end else if (s1_adv) begin
      s1_mant <= in_mant;
      s1_tag  <= in_tag;
      s1_lz   <= lz1_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2 <= '0;
    end else if (s2_adv) begin
      s2.mant <= mant2;
      s2.lz   <= s1_lz;
      s2.zero <= s1_lz[M];
      s2.tag  <= s1_tag;
    end
  end

  assign out_valid = s2_valid;
  assign out_mant  = s2.mant;
  assign out_lz    = s2.lz;
  assign out_zero  = s2.zero;
  assign out_tag   = s2.tag;

endmodule

// File: tb/tb_normalize_pipe.sv
// Scoreboard bench for normalize_pipe: driver pushes expected results, monitor pops and compares.
module tb_normalize_pipe;

  typedef struct packed {
    logic [63:0] mant;
    logic [6:0]  lz;
    logic        zero;
    logic [7:0]  tag;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_mant;
  logic [7:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_mant;
  logic [6:0]  out_lz;
  logic        out_zero;
  logic [7:0]  out_tag;

  exp_t sb_q[$];
  int   checks = 0;
  int   failures = 0;
  int   cycle = 0;
  int   pop_cycle [256];
  logic stream_mode = 1'b0;
  logic rand_mode = 1'b0;

  normalize_pipe #(.N(64), .M(6), .TAGW(8)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_mant(in_mant), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_mant(out_mant),
    .out_lz(out_lz), .out_zero(out_zero), .out_tag(out_tag)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, actual, expected, cycle);
    end
  endtask

  function automatic exp_t refModel(input logic [63:0] m, input logic [7:0] t);
    exp_t e;
    int   lz;
    lz = 64;
    for (int i = 63; i >= 0; i--) begin
      if (m[i]) begin
        lz = 63 - i;
        break;
      end
    end
    e.lz   = 7'(lz);
    e.zero = (lz == 64);
    e.mant = (lz == 64) ? 64'h0 : (m << lz);
    e.tag  = t;
    return e;
  endfunction

  function automatic logic [63:0] randMant();
    logic [63:0] r;
    r = {$urandom, $urandom};
    return r >> $urandom_range(0, 64);
  endfunction

  // Monitor: compares each transferred beat and checks outputs hold across stalls.
  logic        prev_stall = 1'b0;
  logic        prev_flush = 1'b0;
  logic [79:0] prev_out = '0;
  always @(negedge clk) begin
    logic [79:0] cur;
    exp_t        e;
    cur = {out_mant, out_lz, out_zero, out_tag};
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && !prev_flush)
        checkOutput("stall_hold", {out_valid, cur}, {1'b1, prev_out});
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL unexpected_beat: got tag %0h expected no output (cycle %0d)", out_tag, cycle);
        end else begin
          e = sb_q.pop_front();
          checkOutput("beat", cur, e);
          if (stream_mode) pop_cycle[out_tag] = cycle;
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_out   = cur;
      prev_flush = flush;
    end
  end

  always begin
    @(posedge clk);
    #1;
    if (rand_mode) out_ready = 1'($urandom_range(0, 1));
  end

  task automatic driveCycle(input logic v, input logic [63:0] m, input logic [7:0] t,
                            input logic f, output logic acc);
    in_valid = v;
    in_mant  = m;
    in_tag   = t;
    flush    = f;
    @(negedge clk);
    acc = v && in_ready && !f;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    flush    = 1'b0;
  endtask

  task automatic idleCycles(input int n);
    logic acc;
    repeat (n) driveCycle(1'b0, 64'h0, 8'h0, 1'b0, acc);
  endtask

  task automatic applyStimulus(input logic [63:0] m, input logic [7:0] t, input exp_t e);
    logic acc;
    int   n;
    acc = 1'b0;
    n = 0;
    while (!acc && n < 200) begin
      driveCycle(1'b1, m, t, 1'b0, acc);
      n++;
    end
    if (!acc) begin
      checks++;
      failures++;
      $display("[TB] FAIL accept_timeout: got no accept expected accept for tag %0h", t);
    end else begin
      sb_q.push_back(e);
    end
  endtask

  task automatic drainQueue();
    int n;
    out_ready = 1'b1;
    n = 0;
    while (sb_q.size() > 0 && n < 500) begin
      idleCycles(1);
      n++;
    end
    checkOutput("drain_empty", sb_q.size(), 0);
    idleCycles(2);
  endtask

  task automatic singleBeat(input logic [63:0] m, input logic [7:0] t,
                            input logic [63:0] em, input logic [6:0] el, input logic ez);
    applyStimulus(m, t, '{mant: em, lz: el, zero: ez, tag: t});
    @(negedge clk);
    checkOutput("latency_c1_valid", out_valid, 0);
    @(negedge clk);
    checkOutput("latency_c2_valid", out_valid, 1);
    @(posedge clk);
    #1;
    idleCycles(2);
  endtask

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: got no finish expected finish by time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic acc;
    int   start;
    int   accepts;
    int   guard;
    logic [63:0] m;

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_mant = '0; in_tag = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_in_ready", in_ready, 1);
    checkOutput("rst_out_mant", out_mant, 0);
    checkOutput("rst_out_lz", out_lz, 0);
    checkOutput("rst_out_zero", out_zero, 0);
    checkOutput("rst_out_tag", out_tag, 0);
    rst = 1'b0;
    idleCycles(2);

    $display("[TB] directed single beats");
    singleBeat(64'h8000_0000_0000_0000, 8'h11, 64'h8000_0000_0000_0000, 7'd0, 1'b0);
    singleBeat(64'h0000_0001_0000_0000, 8'h22, 64'h8000_0000_0000_0000, 7'd31, 1'b0);
    singleBeat(64'h0000_0000_0000_0001, 8'h33, 64'h8000_0000_0000_0000, 7'd63, 1'b0);
    singleBeat(64'h0000_0000_0000_0000, 8'h44, 64'h0000_0000_0000_0000, 7'd64, 1'b1);
    singleBeat(64'h00F0_0000_0000_0000, 8'h55, 64'hF000_0000_0000_0000, 7'd8, 1'b0);
    singleBeat(64'h0000_0000_0000_0003, 8'h66, 64'hC000_0000_0000_0000, 7'd62, 1'b0);
    drainQueue();

    $display("[TB] streaming");
    stream_mode = 1'b1;
    start = cycle;
    for (int i = 0; i < 100; i++) begin
      m = randMant();
      applyStimulus(m, 8'(i), refModel(m, 8'(i)));
    end
    checkOutput("stream_accept_cycles", cycle - start, 100);
    drainQueue();
    stream_mode = 1'b0;
    checkOutput("stream_no_bubble", pop_cycle[99] - pop_cycle[0], 99);

    $display("[TB] backpressure");
    out_ready = 1'b0;
    accepts = 0;
    for (int c = 0; c < 7; c++) begin
      m = randMant();
      driveCycle(1'b1, m, 8'(200 + c), 1'b0, acc);
      if (acc) begin
        sb_q.push_back(refModel(m, 8'(200 + c)));
        accepts++;
      end
    end
    checkOutput("bp_accepts", accepts, 2);
    checkOutput("bp_in_ready", in_ready, 0);
    checkOutput("bp_out_valid", out_valid, 1);
    drainQueue();

    $display("[TB] random backpressure");
    rand_mode = 1'b1;
    accepts = 0;
    guard = 0;
    while (accepts < 2000 && guard < 20000) begin
      logic v;
      v = 1'($urandom_range(0, 1));
      m = randMant();
      driveCycle(v, m, 8'(accepts), 1'b0, acc);
      if (acc) begin
        sb_q.push_back(refModel(m, 8'(accepts)));
        accepts++;
      end
      guard++;
    end
    rand_mode = 1'b0;
    out_ready = 1'b1;
    checkOutput("rand_accepts", accepts, 2000);
    drainQueue();

    $display("[TB] flush with stage 1 busy");
    m = 64'h0000_0000_00AB_CDEF;
    applyStimulus(m, 8'hA0, refModel(m, 8'hA0));
    driveCycle(1'b1, 64'h1234, 8'hA1, 1'b1, acc);
    sb_q.delete();
    @(negedge clk);
    checkOutput("flush1_out_valid", out_valid, 0);
    @(posedge clk);
    #1;
    idleCycles(4);
    checkOutput("flush1_queue", sb_q.size(), 0);

    $display("[TB] flush with two beats in flight");
    out_ready = 1'b0;
    applyStimulus(64'h0000_0F00_0000_0000, 8'hB0, refModel(64'h0000_0F00_0000_0000, 8'hB0));
    applyStimulus(64'h0000_0000_0000_0100, 8'hB1, refModel(64'h0000_0000_0000_0100, 8'hB1));
    driveCycle(1'b1, 64'h0040_0000_0000_0000, 8'hB2, 1'b1, acc);
    sb_q.delete();
    @(negedge clk);
    checkOutput("flush2_out_valid", out_valid, 0);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    idleCycles(4);
    singleBeat(64'h0040_0000_0000_0000, 8'hB2, 64'h8000_0000_0000_0000, 7'd9, 1'b0);
    drainQueue();

    $display("[TB] reset mid-stream");
    out_ready = 1'b0;
    applyStimulus(64'h0000_0000_FFFF_0000, 8'hC0, refModel(64'h0000_0000_FFFF_0000, 8'hC0));
    applyStimulus(64'h0100_0000_0000_0000, 8'hC1, refModel(64'h0100_0000_0000_0000, 8'hC1));
    #2;
    rst = 1'b1;
    #1;
    sb_q.delete();
    checkOutput("midrst_out_valid", out_valid, 0);
    checkOutput("midrst_in_ready", in_ready, 1);
    checkOutput("midrst_out_mant", out_mant, 0);
    checkOutput("midrst_out_tag", out_tag, 0);
    @(posedge clk);
    #3;
    rst = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    idleCycles(6);
    checkOutput("midrst_after_valid", out_valid, 0);
    checkOutput("midrst_queue", sb_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
